// File: rtl/shift_reg_pkg.sv
// Shared constants and helpers for the serial-in parallel-out shift register.
// Optional build macro: SHIFT_REG_MSB_FIRST_EN (right shift, d enters the MSB).
package shift_reg_pkg;

    localparam int SR_DEFAULT_WIDTH = 4;
    localparam int SR_MIN_WIDTH     = 2;
    localparam int SR_MAX_WIDTH     = 64;

    // Widest legal state vector; narrower instances take the low bits.
    typedef logic [SR_MAX_WIDTH-1:0] sr_vec_t;

    function automatic sr_vec_t sr_reset_val(input int width);
        sr_vec_t v;
        v = '0;
        return v >> (SR_MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/shift_reg_stage.sv
// One storage bit of the shift register: flop with synchronous reset.
// Optional build macro: SHIFT_REG_MSB_FIRST_EN (handled by the parent).
module shift_reg_stage (
    input  logic clk,
    input  logic reset,
    input  logic reset_val,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= reset_val;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_reg_sipo.sv
// Serial-in, parallel-out shift register built from a chain of stages.
// Optional build macro: SHIFT_REG_MSB_FIRST_EN (d enters q[WIDTH-1]).
module shift_reg_sipo
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = SR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(sr_reset_val(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < SR_MIN_WIDTH || WIDTH > SR_MAX_WIDTH) begin : g_bad_width
        $error("shift_reg_sipo: WIDTH %0d outside 2..64", WIDTH);
    end

    logic [WIDTH-1:0] nxt;

`ifdef SHIFT_REG_MSB_FIRST_EN
    assign nxt = {d, q[WIDTH-1:1]};
`else
    assign nxt = {q[WIDTH-2:0], d};
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        shift_reg_stage u_stage (
            .clk       (clk),
            .reset     (reset),
            .reset_val (RESET_VAL[i]),
            .d         (nxt[i]),
            .q         (q[i])
        );
    end

`ifndef SYNTHESIS
    // Gates the shift check until q holds defined data.
    logic seen_rst;

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_rst <= 1'b1;
        end
    end

    a_reset_val: assert property (
        @(posedge clk) $past(reset) |-> (q == RESET_VAL)
    );

`ifdef SHIFT_REG_MSB_FIRST_EN
    a_shift_in: assert property (
        @(posedge clk) (seen_rst && !$past(reset))
            |-> (q[WIDTH-1] == $past(d))
    );
`else
    a_shift_in: assert property (
        @(posedge clk) (seen_rst && !$past(reset))
            |-> (q[0] == $past(d))
    );
`endif
`endif

endmodule

// File: tb/tb_shift_reg_sipo.sv
// Self-checking bench for shift_reg_sipo, WIDTH=4 default and WIDTH=8/A5.
// Honours SHIFT_REG_MSB_FIRST_EN when the design is built with it.
module tb_shift_reg_sipo;

    logic       clk;
    logic       reset;
    logic       d;
    logic [3:0] q4;
    logic [7:0] q8;

    int checks;
    int fails;

    shift_reg_sipo #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q4)
    );

    shift_reg_sipo #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of bits since the last reset, newest first.
    logic hist[$];
    int   since_rst;
    bit   model_valid;

    initial begin
        since_rst   = 0;
        model_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            since_rst   = 0;
            model_valid = 1'b1;
        end else begin
            hist.push_front(d);
            if (hist.size() > 64) void'(hist.pop_back());
            since_rst = since_rst + 1;
        end
    end

    // Bit that entered k edges ago lands k stages from the entry end;
    // stages not yet reached by new data show the reset value, shifted.
    function automatic logic [63:0] model_q(input int w,
                                           input logic [63:0] rv);
        logic [63:0] r;
        logic        b;
        r = '0;
        for (int k = 0; k < w; k++) begin
`ifdef SHIFT_REG_MSB_FIRST_EN
            b = (k < since_rst) ? hist[k] : rv[w-1-(k-since_rst)];
            r[w-1-k] = b;
`else
            b = (k < since_rst) ? hist[k] : rv[k-since_rst];
            r[k] = b;
`endif
        end
        return r;
    endfunction

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_q4", {60'd0, q4}, model_q(4, 64'h0));
            chk("model_q8", {56'd0, q8}, model_q(8, 64'hA5));
        end
    end

    task automatic cyc(input logic r, input logic dv);
        reset = r;
        d     = dv;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_load [4];
    logic [3:0] exp_ovf  [4];
    logic [3:0] exp_mid;
    logic [3:0] exp_post;
    logic [31:0] pat;
    logic [3:0]  ld_bits;

    initial begin
        checks = 0;
        fails  = 0;
`ifdef SHIFT_REG_MSB_FIRST_EN
        exp_load = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        exp_ovf  = '{4'b0110, 4'b0011, 4'b0001, 4'b0000};
        exp_mid  = 4'b1101;
        exp_post = 4'b1000;
`else
        exp_load = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        exp_ovf  = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
        exp_mid  = 4'b1011;
        exp_post = 4'b0001;
`endif
        ld_bits = 4'b1101;
        pat     = 32'hC3A5_9E17;
        reset   = 1'b1;
        d       = 1'b0;

        // Reset held two edges with d toggling.
        cyc(1'b1, 1'b1);
        chk("rst1_q4", {60'd0, q4}, 64'h0);
        chk("rst1_q8", {56'd0, q8}, 64'hA5);
        cyc(1'b1, 1'b0);
        chk("rst2_q4", {60'd0, q4}, 64'h0);
        chk("rst2_q8", {56'd0, q8}, 64'hA5);

        // Serial load 1,0,1,1.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, ld_bits[i]);
            chk("load_q4", {60'd0, q4}, {60'd0, exp_load[i]});
        end

        // Overflow with zeros.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0);
            chk("ovf_q4", {60'd0, q4}, {60'd0, exp_ovf[i]});
        end

        // Reload, then reset mid-stream.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, ld_bits[i]);
        chk("preload_q4", {60'd0, q4}, {60'd0, exp_mid});
        cyc(1'b1, 1'b1);
        chk("midrst_q4", {60'd0, q4}, 64'h0);
        chk("midrst_q8", {56'd0, q8}, 64'hA5);
        cyc(1'b0, 1'b1);
        chk("postrst_q4", {60'd0, q4}, {60'd0, exp_post});

        // Wide instance: reset value, flush with zeros, fill with ones.
        cyc(1'b1, 1'b1);
        chk("w8_rst", {56'd0, q8}, 64'hA5);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
        chk("w8_zero", {56'd0, q8}, 64'h00);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
        chk("w8_ones", {56'd0, q8}, 64'hFF);
        chk("w4_ones", {60'd0, q4}, 64'hF);

        // Irregular pattern, checked every cycle by the model.
        for (int i = 0; i < 32; i++) cyc(1'b0, pat[i]);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, pat[i]);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
